// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register in front of the 64-bit LEGv8 ALU. It captures a
// decoded instruction and its register-file operands, then presents:
//   - ALU operand A (Rn),
//   - ALU operand B (Rm/Rt or an extended immediate),
//   - the 4-bit ALU select code derived from ALUOp and the 11-bit opcode.
// Valid/ready handshakes on both sides give one instruction per cycle when
// downstream keeps up. A flush drops the held entry and any same-cycle input.
//
// Optional build macro: FWD_MUX_EN
//   Adds EX/MEM and MEM/WB forwarding inputs. These select the A source and
//   the register-side B source at capture time.
//
// Parameters
//   DATA_W     operand/result width (must match the ALU)
//   RESET_SEL  ALU_Sel value presented after reset or flush (pass-B)
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   in_valid       in   upstream presents an instruction
//   in_ready       out  stage can accept this cycle (combinational)
//   instr          in   raw 32-bit instruction word
//   rs1_data       in   register Rn value
//   rs2_data       in   register Rm/Rt value
//   alu_op         in   ALUOp from main control
//   alu_src        in   1: B from immediate, 0: B from rs2_data
//   imm_sel        in   immediate format (00 D, 01 CB, 10 I, 11 B)
//   flush          in   discard held entry and same-cycle input
//   out_valid      out  A/B/ALU_Sel hold a live instruction
//   out_ready      in   downstream accepts this cycle
//   A              out  ALU operand A
//   B              out  ALU operand B
//   ALU_Sel        out  ALU operation code
//   out_rd         out  destination register instr[4:0]
//   out_illegal    out  unknown R-type opcode captured
//   fwd_exmem_data in   (FWD_MUX_EN) EX/MEM forwarded value
//   fwd_memwb_data in   (FWD_MUX_EN) MEM/WB forwarded value
//   fwd_a_sel      in   (FWD_MUX_EN) A source select
//   fwd_b_sel      in   (FWD_MUX_EN) register-side B source select
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int         DATA_W    = 64,
    parameter logic [3:0] RESET_SEL = 4'b0111
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [1:0]        alu_op,
    input  logic              alu_src,
    input  logic [1:0]        imm_sel,
    input  logic              flush,
`ifdef FWD_MUX_EN
    input  logic [DATA_W-1:0] fwd_exmem_data,
    input  logic [DATA_W-1:0] fwd_memwb_data,
    input  logic [1:0]        fwd_a_sel,
    input  logic [1:0]        fwd_b_sel,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [3:0]        ALU_Sel,
    output logic [4:0]        out_rd,
    output logic              out_illegal
);

    // ALU operation codes
    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_ORR = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_PSB = 4'b0111;
    localparam logic [3:0] SEL_NOR = 4'b1100;

    // R-type opcodes, instr[31:21]
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    // -----------------------------------------------------------------------
    // Immediate extension. Only the I-type field is unsigned.
    // -----------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] imm_extend(
        input logic [31:0] ins,
        input logic [1:0]  fmt
    );
        logic [DATA_W-1:0] r;
        case (fmt)
            2'b00:   r = {{(DATA_W-9){ins[20]}},  ins[20:12]};
            2'b01:   r = {{(DATA_W-19){ins[23]}}, ins[23:5]};
            2'b10:   r = {{(DATA_W-12){1'b0}},    ins[21:10]};
            default: r = {{(DATA_W-26){ins[25]}}, ins[25:0]};
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // ALU control. Returns {illegal, sel}. Unknown R-type opcodes still
    // produce a harmless add so the ALU never sees an undefined code.
    // -----------------------------------------------------------------------
    function automatic logic [4:0] alu_decode(
        input logic [1:0]  op,
        input logic [10:0] opc
    );
        logic [4:0] r;
        case (op)
            2'b00: r = {1'b0, SEL_ADD};
            2'b01: r = {1'b0, SEL_PSB};
            2'b10: begin
                case (opc)
                    OPC_ADD: r = {1'b0, SEL_ADD};
                    OPC_SUB: r = {1'b0, SEL_SUB};
                    OPC_AND: r = {1'b0, SEL_AND};
                    OPC_ORR: r = {1'b0, SEL_ORR};
                    default: r = {1'b1, SEL_ADD};
                endcase
            end
            default: r = {1'b0, SEL_NOR};
        endcase
        return r;
    endfunction

`ifdef FWD_MUX_EN
    // EX/MEM wins when both forwarding paths are requested
    function automatic logic [DATA_W-1:0] fwd_pick(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_v,
        input logic [DATA_W-1:0] exmem_v,
        input logic [DATA_W-1:0] memwb_v
    );
        logic [DATA_W-1:0] r;
        case (sel)
            2'b00:   r = reg_v;
            2'b01:   r = memwb_v;
            default: r = exmem_v;
        endcase
        return r;
    endfunction
`endif

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] a_q,       a_d;
    logic [DATA_W-1:0] b_q,       b_d;
    logic [3:0]        sel_q,     sel_d;
    logic [4:0]        rd_q,      rd_d;
    logic              illegal_q, illegal_d;

    // -----------------------------------------------------------------------
    // Capture-side datapath (combinational)
    // -----------------------------------------------------------------------
    logic              accept;
    logic [DATA_W-1:0] a_src;
    logic [DATA_W-1:0] rs2_src;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] b_src;
    logic [4:0]        dec;

    assign in_ready = ~valid_q | out_ready;
    // Flush takes priority over any same-cycle accept
    assign accept   = in_valid & in_ready & ~flush;

`ifdef FWD_MUX_EN
    assign a_src   = fwd_pick(fwd_a_sel, rs1_data, fwd_exmem_data, fwd_memwb_data);
    assign rs2_src = fwd_pick(fwd_b_sel, rs2_data, fwd_exmem_data, fwd_memwb_data);
`else
    assign a_src   = rs1_data;
    assign rs2_src = rs2_data;
`endif

    // Forwarding only ever replaces the register side of B, never the immediate
    assign imm_ext = imm_extend(instr, imm_sel);
    assign b_src   = alu_src ? imm_ext : rs2_src;
    assign dec     = alu_decode(alu_op, instr[31:21]);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;

        if (flush) begin
            valid_d = 1'b0;
            sel_d   = RESET_SEL;
        end else if (accept) begin
            valid_d   = 1'b1;
            a_d       = a_src;
            b_d       = b_src;
            sel_d     = dec[3:0];
            rd_d      = instr[4:0];
            illegal_d = dec[4];
        end else if (in_ready) begin
            // Either drained this cycle or already empty; data is left as is
            valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Stage register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= RESET_SEL;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid   = valid_q;
    assign A           = a_q;
    assign B           = b_q;
    assign ALU_Sel     = sel_q;
    assign out_rd      = rd_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int         DATA_W    = 64;
    localparam logic [3:0] RESET_SEL = 4'b0111;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [1:0]        alu_op;
    logic              alu_src;
    logic [1:0]        imm_sel;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [3:0]        ALU_Sel;
    logic [4:0]        out_rd;
    logic              out_illegal;
`ifdef FWD_MUX_EN
    logic [DATA_W-1:0] fwd_exmem_data;
    logic [DATA_W-1:0] fwd_memwb_data;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
`endif

    id_ex_stage #(.DATA_W(DATA_W), .RESET_SEL(RESET_SEL)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_op(alu_op), .alu_src(alu_src), .imm_sel(imm_sel), .flush(flush),
`ifdef FWD_MUX_EN
        .fwd_exmem_data(fwd_exmem_data), .fwd_memwb_data(fwd_memwb_data),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state: what the stage should be presenting
    logic        m_valid;
    logic [63:0] m_a, m_b;
    logic [3:0]  m_sel;
    logic [4:0]  m_rd;
    logic        m_ill;

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [1:0] fmt);
        longint f;
        case (fmt)
            2'b00: begin f = longint'((ins >> 12) & 32'h1FF);    if (f >= 256)      f -= 512;      end
            2'b01: begin f = longint'((ins >> 5) & 32'h7FFFF);   if (f >= 262144)   f -= 524288;   end
            2'b10: begin f = longint'((ins >> 10) & 32'hFFF);                                      end
            default: begin f = longint'(ins & 32'h3FFFFFF);      if (f >= 33554432) f -= 67108864; end
        endcase
        return 64'(f);
    endfunction

    function automatic logic [4:0] ref_ctrl(input logic [1:0] op, input int opc);
        if (op == 2'd0) return 5'h02;
        if (op == 2'd1) return 5'h07;
        if (op == 2'd3) return 5'h0C;
        if (opc == 'h458) return 5'h02;
        if (opc == 'h658) return 5'h06;
        if (opc == 'h450) return 5'h00;
        if (opc == 'h550) return 5'h01;
        return 5'h12;   // illegal flag plus add
    endfunction

    task automatic model_reset();
        m_valid = 0; m_a = 0; m_b = 0; m_sel = RESET_SEL; m_rd = 0; m_ill = 0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_valid"},   64'(out_valid),   64'(m_valid));
        check({pfx, "_A"},       A,                m_a);
        check({pfx, "_B"},       B,                m_b);
        check({pfx, "_sel"},     64'(ALU_Sel),     64'(m_sel));
        check({pfx, "_rd"},      64'(out_rd),      64'(m_rd));
        check({pfx, "_illegal"}, 64'(out_illegal), 64'(m_ill));
    endtask

    // One clock: inputs already applied. Checks in_ready mid-cycle, advances
    // the model, then checks registered outputs just after the edge.
    task automatic cycle(input string pfx);
        logic        rdy;
        logic [63:0] a_src, r2_src;
        logic [4:0]  c;
        @(negedge clk);
        rdy = !m_valid || out_ready;
        check({pfx, "_in_ready"}, 64'(in_ready), 64'(rdy));
        a_src = rs1_data; r2_src = rs2_data;
`ifdef FWD_MUX_EN
        if (fwd_a_sel == 2'b01) a_src = fwd_memwb_data;
        else if (fwd_a_sel != 2'b00) a_src = fwd_exmem_data;
        if (fwd_b_sel == 2'b01) r2_src = fwd_memwb_data;
        else if (fwd_b_sel != 2'b00) r2_src = fwd_exmem_data;
`endif
        if (flush) begin
            m_valid = 0; m_sel = RESET_SEL;
        end else if (in_valid && rdy) begin
            c = ref_ctrl(alu_op, int'(instr >> 21));
            m_valid = 1;
            m_a = a_src;
            m_b = alu_src ? ref_imm(instr, imm_sel) : r2_src;
            m_sel = c[3:0];
            m_ill = c[4];
            m_rd = instr[4:0];
        end else if (rdy) begin
            m_valid = 0;
        end
        @(posedge clk); #1;
        check_outputs(pfx);
    endtask

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [63:0] r1,
                          input logic [63:0] r2, input logic [1:0] op, input logic src,
                          input logic [1:0] isel, input logic fl, input logic ordy);
        in_valid = v; instr = ins; rs1_data = r1; rs2_data = r2; alu_op = op;
        alu_src = src; imm_sel = isel; flush = fl; out_ready = ordy;
    endtask

    int opc_tab [4] = '{'h458, 'h658, 'h450, 'h550};

    initial begin
        logic [31:0] ins;
        rst = 1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef FWD_MUX_EN
        fwd_exmem_data = 0; fwd_memwb_data = 0; fwd_a_sel = 0; fwd_b_sel = 0;
`endif
        model_reset();
        #12;
        check_outputs("rst");
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst = 0;

        // ADD X3,X1,X2
        set_in(1, 32'h8B020023, 64'd5, 64'd7, 2'b10, 0, 2'b00, 0, 1);
        cycle("add");
        check("add_A_k", A, 64'd5);
        check("add_B_k", B, 64'd7);
        check("add_sel_k", 64'(ALU_Sel), 64'h2);
        check("add_rd_k", 64'(out_rd), 64'd3);

        // LDUR X5,[X1,#-8]
        set_in(1, 32'hF85F8025, 64'h100, 64'h1234, 2'b00, 1, 2'b00, 0, 1);
        cycle("ldur");
        check("ldur_A_k", A, 64'h100);
        check("ldur_B_k", B, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldur_rd_k", 64'(out_rd), 64'd5);

        // Backpressure: three stalled cycles, then release
        set_in(1, 32'hCB020064, 64'd9, 64'd4, 2'b10, 0, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("bp");
            check("bp_hold_A_k", A, 64'h100);
        end
        out_ready = 1;
        cycle("bp_rel");
        check("bp_rel_sel_k", 64'(ALU_Sel), 64'h6);
        check("bp_rel_rd_k", 64'(out_rd), 64'd4);

        // Flush with a simultaneous accept
        set_in(1, 32'h8A020025, 64'd1, 64'd2, 2'b10, 0, 2'b00, 1, 1);
        cycle("flush");
        check("flush_valid_k", 64'(out_valid), 64'd0);
        check("flush_sel_k", 64'(ALU_Sel), 64'h7);

        // Unknown R-type opcode 0x5F0
        set_in(1, 32'hBE000041, 64'd3, 64'd8, 2'b10, 0, 2'b00, 0, 1);
        cycle("illeg");
        check("illeg_sel_k", 64'(ALU_Sel), 64'h2);
        check("illeg_flag_k", 64'(out_illegal), 64'd1);

        // Immediate formats
        set_in(1, 32'hB4FFFFE0, 64'd0, 64'd0, 2'b01, 1, 2'b01, 0, 1);
        cycle("cbz");
        check("cbz_B_k", B, 64'hFFFF_FFFF_FFFF_FFFF);
        set_in(1, 32'h913FFC00, 64'd0, 64'd0, 2'b00, 1, 2'b10, 0, 1);
        cycle("itype");
        check("itype_B_k", B, 64'hFFF);
        set_in(1, 32'h16000000, 64'd0, 64'd0, 2'b11, 1, 2'b11, 0, 1);
        cycle("btype");
        check("btype_B_k", B, 64'hFFFF_FFFF_FE00_0000);
        check("btype_sel_k", 64'(ALU_Sel), 64'hC);

`ifdef FWD_MUX_EN
        fwd_exmem_data = 64'hAA; fwd_memwb_data = 64'hBB; fwd_a_sel = 2'b11; fwd_b_sel = 2'b01;
        set_in(1, 32'hF85F8025, 64'd1, 64'd2, 2'b00, 1, 2'b00, 0, 1);
        cycle("fwd");
        check("fwd_A_k", A, 64'hAA);
        check("fwd_B_k", B, 64'hFFFF_FFFF_FFFF_FFF8);
        alu_src = 0;
        cycle("fwd_reg");
        check("fwd_reg_B_k", B, 64'hBB);
`endif

        // Reset mid-stream, observed without any clock edge
        set_in(1, 32'h8B020023, 64'd5, 64'd7, 2'b10, 0, 2'b00, 0, 1);
        cycle("pre_rst");
        #2; rst = 1; #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_sel", 64'(ALU_Sel), 64'h7);
        check("arst_A", A, 64'd0);
        check("arst_B", B, 64'd0);
        model_reset();
        @(negedge clk); rst = 0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(3) != 0) begin
                ins[31:21] = 11'(opc_tab[$urandom_range(3)]);
            end
            set_in($urandom_range(3) != 0, ins, {$urandom, $urandom}, {$urandom, $urandom},
                   2'($urandom), 1'($urandom), 2'($urandom), $urandom_range(15) == 0,
                   $urandom_range(2) != 0);
`ifdef FWD_MUX_EN
            fwd_exmem_data = {$urandom, $urandom}; fwd_memwb_data = {$urandom, $urandom};
            fwd_a_sel = 2'($urandom); fwd_b_sel = 2'($urandom);
`endif
            cycle("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
